// File: rtl/key_pkg.sv
// ---------------------------------------------------------------------------
// key_pkg
// Shared types and helpers for the push-button event detector.
//   key_state_t : per-key debounce / hold state
//   MCNT_W      : width of the per-key millisecond counter
//   ms_cycles() : number of clk cycles in one millisecond for a MHz clock
// ---------------------------------------------------------------------------
package key_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS_DB,
    PRESSED,
    HELD,
    RELEASE_DB
  } key_state_t;

  localparam int MCNT_W = 16;

  function automatic int ms_cycles(input int clk_fre);
    return clk_fre * 1000;
  endfunction

endpackage

// File: rtl/key_channel.sv
// ---------------------------------------------------------------------------
// key_channel
// One push-button: 2-FF synchronizer, millisecond debounce FSM and
// registered event pulses.
//   clk, rst_n   : clock, asynchronous active-low reset
//   key_in       : raw key pin (asynchronous)
//   tick         : one-cycle strobe once per millisecond (shared)
//   key_level    : debounced state, 1 = pressed
//   key_press    : 1-cycle pulse on debounced press
//   key_release  : 1-cycle pulse on debounced release
//   key_long     : 1-cycle pulse when the hold time reaches LONG_MS
// ---------------------------------------------------------------------------
module key_channel
  import key_pkg::*;
#(
  parameter int DEBOUNCE_MS    = 20,
  parameter int LONG_MS        = 1000,
  parameter int KEY_ACTIVE_LOW = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  input  logic tick,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  // Level the pin shows when the key is not pressed.
  localparam logic PIN_IDLE = (KEY_ACTIVE_LOW != 0);
  localparam logic [MCNT_W-1:0] DB_LIM   = MCNT_W'(DEBOUNCE_MS);
  localparam logic [MCNT_W-1:0] LONG_LIM = MCNT_W'(LONG_MS);

  logic              sync1_reg;
  logic              sync2_reg;
  logic              act;
  key_state_t        state_reg;
  logic [MCNT_W-1:0] mcnt_reg;
  logic [MCNT_W-1:0] mcnt_next;
  logic              long_done_reg;
  logic              level_reg;
  logic              press_reg;
  logic              release_reg;
  logic              long_reg;

  assign act = sync2_reg ^ PIN_IDLE;

  // Count value including this cycle's tick. Comparing this against the
  // limit lets the transition happen on the same edge the limit is reached,
  // and makes a zero limit fire on the very next clock regardless of tick.
  assign mcnt_next = mcnt_reg + {{(MCNT_W-1){1'b0}}, tick};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg     <= PIN_IDLE;
      sync2_reg     <= PIN_IDLE;
      state_reg     <= IDLE;
      mcnt_reg      <= '0;
      long_done_reg <= 1'b0;
      level_reg     <= 1'b0;
      press_reg     <= 1'b0;
      release_reg   <= 1'b0;
      long_reg      <= 1'b0;
    end else begin
      sync1_reg   <= key_in;
      sync2_reg   <= sync1_reg;
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
      long_reg    <= 1'b0;

      case (state_reg)
        IDLE: begin
          level_reg <= 1'b0;
          if (act) begin
            state_reg <= PRESS_DB;
            mcnt_reg  <= '0;
          end
        end

        PRESS_DB: begin
          if (!act) begin
            state_reg <= IDLE;
          end else if (mcnt_next >= DB_LIM) begin
            state_reg     <= PRESSED;
            press_reg     <= 1'b1;
            level_reg     <= 1'b1;
            mcnt_reg      <= '0;
            long_done_reg <= 1'b0;
          end else begin
            mcnt_reg <= mcnt_next;
          end
        end

        PRESSED: begin
          if (!act) begin
            state_reg <= RELEASE_DB;
            mcnt_reg  <= '0;
          end else if (mcnt_next >= LONG_LIM) begin
            state_reg     <= HELD;
            long_reg      <= 1'b1;
            long_done_reg <= 1'b1;
          end else begin
            mcnt_reg <= mcnt_next;
          end
        end

        HELD: begin
          // Long event already issued for this press: no auto-repeat.
          if (!act) begin
            state_reg <= RELEASE_DB;
            mcnt_reg  <= '0;
          end
        end

        RELEASE_DB: begin
          if (act) begin
            // A release glitch: resume the hold, restarting the long timer.
            state_reg <= long_done_reg ? HELD : PRESSED;
            mcnt_reg  <= '0;
          end else if (mcnt_next >= DB_LIM) begin
            state_reg   <= IDLE;
            release_reg <= 1'b1;
            level_reg   <= 1'b0;
          end else begin
            mcnt_reg <= mcnt_next;
          end
        end

        default: begin
          state_reg <= IDLE;
          level_reg <= 1'b0;
        end
      endcase
    end
  end

  assign key_level   = level_reg;
  assign key_press   = press_reg;
  assign key_release = release_reg;
  assign key_long    = long_reg;

endmodule

// File: rtl/key_event_detect.sv
// ---------------------------------------------------------------------------
// key_event_detect
// Converts raw bouncing push-button pins into clean per-key events.
//   clk, rst_n   : clock (CLK_FRE MHz), asynchronous active-low reset
//   key_in       : [KEY_NUM] raw key pins
//   key_level    : [KEY_NUM] debounced state, 1 = pressed
//   key_press    : [KEY_NUM] 1-cycle pulse on debounced press
//   key_release  : [KEY_NUM] 1-cycle pulse on debounced release
//   key_long     : [KEY_NUM] 1-cycle pulse when hold reaches LONG_MS
// A single free-running millisecond counter is shared by all keys.
// ---------------------------------------------------------------------------
module key_event_detect
  import key_pkg::*;
#(
  parameter int CLK_FRE        = 50,
  parameter int KEY_NUM        = 4,
  parameter int DEBOUNCE_MS    = 20,
  parameter int LONG_MS        = 1000,
  parameter int KEY_ACTIVE_LOW = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [KEY_NUM-1:0] key_in,
  output logic [KEY_NUM-1:0] key_level,
  output logic [KEY_NUM-1:0] key_press,
  output logic [KEY_NUM-1:0] key_release,
  output logic [KEY_NUM-1:0] key_long
);

  localparam logic [31:0] MS_MAX = 32'(ms_cycles(CLK_FRE) - 1);

  logic [31:0] ms_cnt_reg;
  logic        tick;

  // Free-running; never restarted by key activity, so tick phase relative
  // to a key edge is arbitrary.
  assign tick = (ms_cnt_reg == MS_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ms_cnt_reg <= '0;
    end else if (tick) begin
      ms_cnt_reg <= '0;
    end else begin
      ms_cnt_reg <= ms_cnt_reg + 32'd1;
    end
  end

  for (genvar gi = 0; gi < KEY_NUM; gi++) begin : g_key
    key_channel #(
      .DEBOUNCE_MS    (DEBOUNCE_MS),
      .LONG_MS        (LONG_MS),
      .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
    ) u_channel (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_in      (key_in[gi]),
      .tick        (tick),
      .key_level   (key_level[gi]),
      .key_press   (key_press[gi]),
      .key_release (key_release[gi]),
      .key_long    (key_long[gi])
    );
  end

endmodule
